// File: rtl/median_window_gen.sv
// rtl/median_window_gen.sv - streaming 3x3 window generator with two line buffers
module median_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 9
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    input  logic                      pixel_valid,
    input  logic                      sof,
    output logic [9*DATA_WIDTH-1:0]   window_out,
    output logic                      win_valid,
    output logic                      frame_done
);

    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(IMG_HEIGHT - 1);
    localparam logic [COL_WIDTH-1:0] COL_TWO  = COL_WIDTH'(2);
    localparam logic [ROW_WIDTH-1:0] ROW_TWO  = ROW_WIDTH'(2);

    logic [COL_WIDTH-1:0]  col;
    logic [ROW_WIDTH-1:0]  row;
    logic [COL_WIDTH-1:0]  cur_col;
    logic [ROW_WIDTH-1:0]  cur_row;
    logic [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] lb2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] mid;

    // A start-of-frame pixel is always (0,0), overriding the running counters.
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        top     = lb2[cur_col];
        mid     = lb1[cur_col];
    end

    // Line buffers carry no reset so they can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (pixel_valid) begin
            lb2[cur_col] <= mid;
            lb1[cur_col] <= pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            window_out <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pixel_valid) begin
                for (int r = 0; r < 3; r++) begin
                    window_out[DATA_WIDTH*(3*r)   +: DATA_WIDTH] <= window_out[DATA_WIDTH*(3*r+1) +: DATA_WIDTH];
                    window_out[DATA_WIDTH*(3*r+1) +: DATA_WIDTH] <= window_out[DATA_WIDTH*(3*r+2) +: DATA_WIDTH];
                end
                window_out[DATA_WIDTH*2 +: DATA_WIDTH] <= top;
                window_out[DATA_WIDTH*5 +: DATA_WIDTH] <= mid;
                window_out[DATA_WIDTH*8 +: DATA_WIDTH] <= pixel_in;

                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + ROW_WIDTH'(1);
                end else begin
                    col <= cur_col + COL_WIDTH'(1);
                    row <= cur_row;
                end

                win_valid  <= (cur_row >= ROW_TWO) && (cur_col >= COL_TWO);
                frame_done <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            end
        end
    end

endmodule

// File: tb/tb_median_window_gen.sv
// tb/tb_median_window_gen.sv - self-checking bench for median_window_gen on a 4x4 image
module tb_median_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   pixel_in;
    logic            pixel_valid;
    logic            sof;
    logic [9*DW-1:0] window_out;
    logic            win_valid;
    logic            frame_done;

    int checks;
    int errors;
    int pulses;
    int mrow;
    int mcol;
    logic [DW-1:0] img [H][W];

    median_window_gen #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_WIDTH (2),
        .ROW_WIDTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .sof        (sof),
        .window_out (window_out),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: positions follow the raster rules; a window is simply the 3x3 patch of the
    // image written so far in this frame, ending at the accepted position.
    task automatic send(input logic [DW-1:0] pix, input logic s);
        int r_pos;
        int c_pos;
        logic ev;
        logic ef;
        logic [71:0] ew;
        @(negedge clk);
        pixel_in    = pix;
        pixel_valid = 1'b1;
        sof         = s;
        r_pos = s ? 0 : mrow;
        c_pos = s ? 0 : mcol;
        img[r_pos][c_pos] = pix;
        ev = (r_pos >= 2) && (c_pos >= 2);
        ef = (r_pos == H-1) && (c_pos == W-1);
        ew = '0;
        if (ev)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    ew[8*(3*r+c) +: 8] = img[r_pos-2+r][c_pos-2+c];
        if (c_pos == W-1) begin
            mcol = 0;
            mrow = (r_pos == H-1) ? 0 : r_pos + 1;
        end else begin
            mcol = c_pos + 1;
            mrow = r_pos;
        end
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        if (win_valid) pulses++;
        check("win_valid", 72'(win_valid), 72'(ev));
        check("frame_done", 72'(frame_done), 72'(ef));
        if (ev) check("window_out", window_out, ew);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pixel_valid = 1'b0;
            sof         = 1'($urandom);
            pixel_in    = DW'($urandom);
            @(posedge clk);
            #1;
            check("idle_win_valid", 72'(win_valid), 72'(0));
            check("idle_frame_done", 72'(frame_done), 72'(0));
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n       = 1'b0;
            pixel_valid = 1'($urandom);
            sof         = 1'($urandom);
            pixel_in    = DW'($urandom);
            @(posedge clk);
            #1;
            check("rst_win_valid", 72'(win_valid), 72'(0));
            check("rst_frame_done", 72'(frame_done), 72'(0));
            check("rst_window_out", window_out, 72'(0));
        end
        @(negedge clk);
        rst_n       = 1'b1;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        mrow = 0;
        mcol = 0;
    endtask

    task automatic send_frame(input int base, input int max_gap, input logic rnd);
        pulses = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(rnd ? DW'($urandom) : DW'(base + 16*r + c), (r == 0) && (c == 0));
                if (max_gap > 0) idle($urandom_range(1, max_gap));
            end
        check("frame_pulses", 72'(pulses), 72'(4));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pulses      = 0;
        mrow        = 0;
        mcol        = 0;
        rst_n       = 1'b0;
        pixel_valid = 1'b0;
        sof         = 1'b0;
        pixel_in    = '0;

        do_reset(3);

        send_frame(8'h00, 0, 1'b0);
        send_frame(8'h00, 3, 1'b0);
        send_frame(8'h80, 0, 1'b0);

        // Abort a frame with sof on its 8th pixel; the restarted frame must emit normally.
        pulses = 0;
        for (int i = 0; i < 7; i++)
            send(DW'(16*(i/W) + (i%W)), i == 0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(DW'(8'hC0 + 16*r + c), (r == 0) && (c == 0));
        check("sof_abort_pulses", 72'(pulses), 72'(4));

        // Reset after (2,1) and restart.
        for (int i = 0; i < 10; i++)
            send(DW'(16*(i/W) + (i%W)), i == 0);
        do_reset(1);
        send_frame(8'h40, 2, 1'b0);

        send_frame(0, 2, 1'b1);
        send_frame(0, 0, 1'b1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
